// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared shift-unit definitions.
// The shift-mode encodings are also used by the ALU opcode decoder, so they
// live here rather than inside the shifter.
package shifter_pkg;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,   // logical left, zero fill at LSB
      OP_SRL = 2'b01,   // logical right, zero fill at MSB
      OP_SRA = 2'b10,   // arithmetic right, sign fill at MSB
      OP_ROR = 2'b11    // rotate right
   } shift_op_e;

   localparam int MIN_WIDTH = 8;

endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// One step of the log-shifter: conditionally shifts by STEP, then registers
// the result together with the sideband fields that later stages need.
//
// Ports:
//   clock, reset_n   rising-edge clock, async active-low reset
//   enable           global pipeline advance; register loads only when high
//   valid_i/_o       stage occupancy
//   data_i/_o        operand / partially shifted operand
//   sham_i/_o        full shift amount (bit log2(STEP) selects this step)
//   op_i/_o          shift mode
//   sign_i/_o        MSB of the original operand, used for SRA fill
//   tag_i/_o         opaque sideband tag
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5,
   parameter int SHW   = 5,
   parameter int STEP  = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic [SHW-1:0]   sham_i,
   input  shift_op_e        op_i,
   input  logic             sign_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [SHW-1:0]   sham_o,
   output shift_op_e        op_o,
   output logic             sign_o,
   output logic [TAG_W-1:0] tag_o
);

   localparam int K = $clog2(STEP);

   logic             valid_q;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SHW-1:0]   sham_q;
   shift_op_e        op_q;
   logic             sign_q;
   logic [TAG_W-1:0] tag_q;

   always_comb begin
      data_d = data_i;
      if (sham_i[K]) begin
         unique case (op_i)
            OP_SLL:  data_d = data_i << STEP;
            OP_SRL:  data_d = data_i >> STEP;
            // Fill from the original operand's sign, not from data_i's MSB:
            // an earlier stage may already have changed the top bits.
            OP_SRA:  data_d = {{STEP{sign_i}}, data_i[WIDTH-1:STEP]};
            OP_ROR:  data_d = {data_i[STEP-1:0], data_i[WIDTH-1:STEP]};
            default: data_d = data_i;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sham_q  <= '0;
         op_q    <= OP_SLL;
         sign_q  <= 1'b0;
         tag_q   <= '0;
      end else if (enable) begin
         valid_q <= valid_i;
         data_q  <= data_d;
         sham_q  <= sham_i;
         op_q    <= op_i;
         sign_q  <= sign_i;
         tag_q   <= tag_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign sham_o  = sham_q;
   assign op_o    = op_q;
   assign sign_o  = sign_q;
   assign tag_o   = tag_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined log-shifter for the execute-stage shift unit (SLL/SRL/SRA/ROR).
// SHW register stages, largest step first; latency SHW cycles, one op/cycle.
// The whole pipeline advances together whenever the output is empty or
// being consumed, so a stalled result freezes every stage behind it.
//
// Ports:
//   clock, reset_n       rising-edge clock, async active-low reset
//   in_valid/in_ready    operand handshake (in_ready is combinational)
//   in_data, in_sham     operand and shift amount
//   in_op                shift mode (shift_op_e encoding)
//   in_tag               sideband tag, returned unchanged on out_tag
//   out_valid/out_ready  result handshake
//   out_data, out_tag    result and its tag
module pipelined_barrel_shifter
   import shifter_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int TAG_W = 5,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_sham,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);

   // Index SHW is the pipeline input, index 0 the output of the last stage.
   logic             valid_s [SHW+1];
   logic [WIDTH-1:0] data_s  [SHW+1];
   logic [SHW-1:0]   sham_s  [SHW+1];
   shift_op_e        op_s    [SHW+1];
   logic             sign_s  [SHW+1];
   logic [TAG_W-1:0] tag_s   [SHW+1];

   logic advance;
   logic unused_tail;

   assign advance  = !valid_s[0] || out_ready;
   assign in_ready = advance;

   // A cycle without in_valid loads a bubble into the first stage.
   assign valid_s[SHW] = in_valid;
   assign data_s[SHW]  = in_data;
   assign sham_s[SHW]  = in_sham;
   assign op_s[SHW]    = shift_op_e'(in_op);
   assign sign_s[SHW]  = in_data[WIDTH-1];
   assign tag_s[SHW]   = in_tag;

   for (genvar k = SHW - 1; k >= 0; k--) begin : g_stage
      shift_stage #(
         .WIDTH (WIDTH),
         .TAG_W (TAG_W),
         .SHW   (SHW),
         .STEP  (1 << k)
      ) u_stage (
         .clock   (clock),
         .reset_n (reset_n),
         .enable  (advance),
         .valid_i (valid_s[k+1]),
         .data_i  (data_s[k+1]),
         .sham_i  (sham_s[k+1]),
         .op_i    (op_s[k+1]),
         .sign_i  (sign_s[k+1]),
         .tag_i   (tag_s[k+1]),
         .valid_o (valid_s[k]),
         .data_o  (data_s[k]),
         .sham_o  (sham_s[k]),
         .op_o    (op_s[k]),
         .sign_o  (sign_s[k]),
         .tag_o   (tag_s[k])
      );
   end

   assign out_valid = valid_s[0];
   assign out_data  = data_s[0];
   assign out_tag   = tag_s[0];

   // Control fields are spent once the last stage has used them.
   assign unused_tail = ^{sham_s[0], op_s[0], sign_s[0]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;

   localparam int WIDTH = 32;
   localparam int TAG_W = 5;
   localparam int SHW   = 5;
   localparam int LAT   = 5;

   localparam logic [1:0] SLL = 2'b00;
   localparam logic [1:0] SRL = 2'b01;
   localparam logic [1:0] SRA = 2'b10;
   localparam logic [1:0] ROR = 2'b11;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic [SHW-1:0]   in_sham = '0;
   logic [1:0]       in_op = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;

   pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sham   (in_sham),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [TAG_W-1:0] tag;
      int               acc_cyc;
      bit               chk_lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every output transfer and checks that a
   // stalled output stays frozen.
   exp_t             e;
   bit               held_prev = 1'b0;
   logic [WIDTH-1:0] held_data;
   logic [TAG_W-1:0] held_tag;

   always @(negedge clock) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got data %h tag %0d, expected none", out_data, out_tag);
         end else begin
            e = sb.pop_front();
            check32("out_data", out_data, e.data);
            check32("out_tag", {27'b0, out_tag}, {27'b0, e.tag});
            if (e.chk_lat) check32("latency", 32'(cyc - e.acc_cyc), LAT);
         end
      end
      if (reset_n && out_valid && !out_ready) begin
         check32("stall_in_ready", {31'b0, in_ready}, 32'd0);
         if (held_prev) begin
            check32("stall_hold_data", out_data, held_data);
            check32("stall_hold_tag", {27'b0, out_tag}, {27'b0, held_tag});
         end
         held_prev = 1'b1;
         held_data = out_data;
         held_tag  = out_tag;
      end else begin
         held_prev = 1'b0;
      end
   end

   // Present one op and wait (bounded) until it is accepted; in_valid stays
   // high afterwards so consecutive calls stream back-to-back.
   task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                       input logic [4:0] tag, input logic [31:0] exp, input bit lat);
      bit ok;
      int n;
      exp_t x;
      ok = 1'b0;
      n  = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_data  = d;
      in_sham  = sh;
      in_tag   = tag;
      while (!ok && n < 60) begin
         @(negedge clock);
         ok = in_ready;
         if (ok) begin
            x.data    = exp;
            x.tag     = tag;
            x.acc_cyc = cyc;
            x.chk_lat = lat;
            sb.push_back(x);
         end
         @(posedge clock);
         #1;
         n++;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: tag %0d not accepted within %0d cycles", tag, n);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clock);
         n++;
      end
      #1;
      check32("drain_pending", sb.size(), 0);
   endtask

   initial begin
      // Reset state
      #2;
      check32("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check32("rst_out_data", out_data, 32'h0);
      check32("rst_out_tag", {27'b0, out_tag}, 32'd0);
      check32("rst_in_ready", {31'b0, in_ready}, 32'd1);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;

      // Single directed ops
      send(SRA, 32'h8000_0000, 5'd4,  5'd1, 32'hF800_0000, 1'b1);
      send(SRL, 32'h8000_0000, 5'd4,  5'd2, 32'h0800_0000, 1'b1);
      send(SLL, 32'h0000_0001, 5'd31, 5'd3, 32'h8000_0000, 1'b1);
      send(ROR, 32'h0000_000F, 5'd4,  5'd4, 32'hF000_0000, 1'b1);
      send(ROR, 32'h8000_0001, 5'd31, 5'd5, 32'h0000_0003, 1'b1);
      drain();

      // Zero shift amount in every mode
      send(SLL, 32'hA5A5_A5A5, 5'd0, 5'd20, 32'hA5A5_A5A5, 1'b1);
      send(SRL, 32'hA5A5_A5A5, 5'd0, 5'd21, 32'hA5A5_A5A5, 1'b1);
      send(SRA, 32'hA5A5_A5A5, 5'd0, 5'd22, 32'hA5A5_A5A5, 1'b1);
      send(ROR, 32'hA5A5_A5A5, 5'd0, 5'd23, 32'hA5A5_A5A5, 1'b1);
      drain();

      // Back-to-back stream, tags 0..7
      send(SLL, 32'h1234_5678, 5'd8,  5'd0, 32'h3456_7800, 1'b1);
      send(SRL, 32'h1234_5678, 5'd8,  5'd1, 32'h0012_3456, 1'b1);
      send(SRA, 32'hF000_0000, 5'd28, 5'd2, 32'hFFFF_FFFF, 1'b1);
      send(SRA, 32'h7000_0000, 5'd28, 5'd3, 32'h0000_0007, 1'b1);
      send(ROR, 32'h1234_5678, 5'd8,  5'd4, 32'h7812_3456, 1'b1);
      send(SLL, 32'hFFFF_FFFF, 5'd16, 5'd5, 32'hFFFF_0000, 1'b1);
      send(SRL, 32'hFFFF_FFFF, 5'd31, 5'd6, 32'h0000_0001, 1'b1);
      send(ROR, 32'hA5A5_A5A5, 5'd1,  5'd7, 32'hD2D2_D2D2, 1'b1);
      drain();

      // Backpressure: 3 accepts, then consumer stalls while producer keeps going
      send(SLL, 32'h0000_0003, 5'd1, 5'd8,  32'h0000_0006, 1'b0);
      send(SRL, 32'h0000_0100, 5'd8, 5'd9,  32'h0000_0001, 1'b0);
      send(SRA, 32'h8000_0000, 5'd31, 5'd10, 32'hFFFF_FFFF, 1'b0);
      out_ready = 1'b0;
      fork
         begin
            send(ROR, 32'h0000_0001, 5'd1,  5'd11, 32'h8000_0000, 1'b0);
            send(SLL, 32'h0000_000F, 5'd28, 5'd12, 32'hF000_0000, 1'b0);
            send(SRL, 32'h8000_0000, 5'd31, 5'd13, 32'h0000_0001, 1'b0);
            send(SRA, 32'h4000_0000, 5'd30, 5'd14, 32'h0000_0001, 1'b0);
            send(ROR, 32'h1234_5678, 5'd16, 5'd15, 32'h5678_1234, 1'b0);
         end
         begin
            repeat (15) @(posedge clock);
            @(negedge clock);
            check32("stall_out_valid", {31'b0, out_valid}, 32'd1);
            check32("stall_ready_low", {31'b0, in_ready}, 32'd0);
            @(posedge clock);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Reset with four ops in flight
      send(SLL, 32'h1111_1111, 5'd1, 5'd16, 32'h2222_2222, 1'b1);
      send(SRL, 32'h2222_2222, 5'd1, 5'd17, 32'h1111_1111, 1'b1);
      send(SRA, 32'h8888_8888, 5'd1, 5'd18, 32'hC444_4444, 1'b1);
      send(ROR, 32'h0000_0002, 5'd1, 5'd19, 32'h0000_0001, 1'b1);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      sb.delete();
      check32("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check32("midrst_out_data", out_data, 32'h0);
      check32("midrst_out_tag", {27'b0, out_tag}, 32'd0);
      check32("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      check32("postrst_quiet", {31'b0, out_valid}, 32'd0);
      send(SLL, 32'h0000_000A, 5'd2, 5'd31, 32'h0000_0028, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined log-shifter covering SLL, SRL, SRA and ROR on WIDTH-bit operands.
- One register stage per power-of-two shift step.
- Valid/ready handshake on both sides; TAG field passed through unchanged for writeback matching.
- Sits in the processor execute path as the shift unit, feeding the writeback/bypass mux.

Parameters:
- WIDTH, 32, operand width; power of two, minimum 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, never overridden.
- TAG_W, 5, width of opaque sideband tag (destination register number).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  shifter accepts operand this cycle.
- in_data  input  WIDTH  operand.
- in_sham  input  SHW  shift amount.
- in_op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag matching out_data.

Behaviour:
- Pipeline has SHW stages.
  - Stage k (k = SHW-1 down to 0) conditionally shifts by 2^k, using bit k of the carried shift amount.
  - Largest step first.
  - Each stage registers data, remaining shift bits, op, tag and a valid bit.
- Latency: exactly SHW cycles from accepted input to out_valid (5 for WIDTH=32) with no stall.
- Throughput: one operation per cycle.
- Global advance = !out_valid || out_ready.
  - All stage registers load only when advance = 1, otherwise all hold.
  - in_ready = advance (combinational).
  - A transfer occurs when in_valid && in_ready; otherwise a bubble (valid = 0) enters stage SHW-1.
- Fill rules per mode at each step:
  - SLL: zero fill at LSB.
  - SRL: zero fill at MSB.
  - SRA: fill with bit WIDTH-1 of the original operand, carried through the stages.
  - ROR: bits shifted out of LSB re-enter at MSB.
- in_sham = 0: data passes unchanged in all modes, same latency.
- Maximum shift WIDTH-1. ROR by WIDTH-1 equals rotate left by 1.
- Reset (reset_n low, any time, including mid-stream):
  - All valid bits clear immediately (async); out_valid = 0.
  - out_data = 0, out_tag = 0; data registers cleared to 0.
  - In-flight operations are discarded.
  - in_ready = 1 once out_valid = 0, including during reset.
- First accept after reset deassertion: earliest at the first rising edge with reset_n high.
- out_data/out_tag hold stable while out_valid && !out_ready.
- Simultaneous accept and emit is permitted; no bubble is inserted.
- Illegal op values: none, since all four encodings are defined.

Decomposition:
- Shared package shifter_pkg:
  - SHIFT_OP typedef/localparams OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11.
  - The same constants are used by the ALU opcode decoder.
- Sub-module shift_stage, parameterised by WIDTH, TAG_W and STEP:
  - One conditional shift by STEP plus its pipeline register and valid bit.
  - Inputs: enable (= advance), reset_n, clock.
- Top level instantiates SHW copies via generate and derives advance/in_ready.

Test Plan:
- SRA, in_data = 0x80000000, sham = 4 -> out_data = 0xF8000000 after 5 cycles. SRL same input -> 0x08000000.
- SLL 0x00000001 by 31 -> 0x80000000. ROR 0x0000000F by 4 -> 0xF0000000. ROR 0x80000001 by 31 -> 0x00000003.
- Back-to-back stream of 8 ops with out_ready = 1 and tags 0..7 -> results and tags emerge in order, one per cycle, starting cycle 5.
- Hold out_ready = 0 after 3 accepts, keep in_valid = 1 -> out_valid rises, in_ready drops, outputs stable. Release -> all ops delivered exactly once, no loss or duplication.
- sham = 0 in all four modes on 0xA5A5A5A5 -> unchanged output.
- Assert reset_n low with 4 ops in flight -> out_valid = 0 at once, out_data = 0. After release, no stale results appear; a new op completes in 5 cycles.
